// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry path: FSM states and
// the constants of the reverse double-dabble conversion.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    localparam int BCD_W         = 4;
    localparam int DIGIT_MAX     = 9;
    localparam int ITER          = 10;
    localparam int DABBLE_THRESH = 8;
    localparam int DABBLE_ADJ    = 3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction cell: a BCD nibble that reached 8 or
// more after the right shift has 3 taken off to keep it a valid decimal digit.
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_W'(DABBLE_THRESH)) begin
            o_digit = i_digit - BCD_W'(DABBLE_ADJ);
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: turns a 3-digit BCD entry into a saturated
// binary operand, one bit per cycle, with a start/done handshake.
module bcd_to_binary
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int OUT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] bin_out,
    output logic             overflow,
    output logic             digit_err
);

    localparam int BW = NUM_DIGITS * BCD_W;
    localparam logic [ITER-1:0] MAX_OUT = ITER'((1 << OUT_W) - 1);

    if (NUM_DIGITS != 3) begin : g_bad_digits
        $error("bcd_to_binary supports only NUM_DIGITS == 3");
    end

    state_t           r_state;
    logic [BW-1:0]    r_b;
    logic [ITER-1:0]  r_r;
    logic [3:0]       r_cnt;
    logic             r_err;
    logic             r_busy;
    logic             r_done;
    logic [OUT_W-1:0] r_bin;
    logic             r_ovf;
    logic             r_derr;

    logic [BW-1:0]    w_b_shift;
    logic [BW-1:0]    w_b_adj;
    logic [ITER-1:0]  w_r_next;
    logic             w_digit_bad;
    logic             w_sat;

    assign w_b_shift   = r_b >> 1;
    assign w_r_next    = {r_b[0], r_r[ITER-1:1]};
    assign w_sat       = (w_r_next > MAX_OUT);
    assign w_digit_bad = (hundreds > BCD_W'(DIGIT_MAX)) ||
                         (tens     > BCD_W'(DIGIT_MAX)) ||
                         (ones     > BCD_W'(DIGIT_MAX));

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (w_b_shift[g*BCD_W +: BCD_W]),
            .o_digit (w_b_adj[g*BCD_W +: BCD_W])
        );
    end

    // An illegal entry still spends one CONVERT cycle so that its done lands
    // one cycle after start is sampled; the datapath is left untouched there.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_b     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= '0;
            r_ovf   <= 1'b0;
            r_derr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_b     <= {hundreds, tens, ones};
                        r_r     <= '0;
                        r_cnt   <= '0;
                        r_err   <= w_digit_bad;
                        r_busy  <= 1'b1;
                        r_state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (r_err) begin
                        r_done  <= 1'b1;
                        r_bin   <= '0;
                        r_ovf   <= 1'b0;
                        r_derr  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_b   <= w_b_adj;
                        r_r   <= w_r_next;
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'(ITER - 1)) begin
                            r_done  <= 1'b1;
                            r_bin   <= w_sat ? '1 : w_r_next[OUT_W-1:0];
                            r_ovf   <= w_sat;
                            r_derr  <= 1'b0;
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign bin_out   = r_bin;
    assign overflow  = r_ovf;
    assign digit_err = r_derr;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: directed digit entries push expected
// results, an independent monitor pops and compares on every done pulse.
module tb_bcd_to_binary;

    typedef struct {
        logic [7:0] bin;
        logic       ovf;
        logic       err;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic       start;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [7:0] bin_out;
    logic       overflow;
    logic       digit_err;

    int   checks;
    int   errors;
    exp_t q[$];
    logic prev_done;

    bcd_to_binary #(.NUM_DIGITS(3), .OUT_W(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .overflow  (overflow),
        .digit_err (digit_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST_N && done) begin
            chk("done_single_cycle", int'(prev_done), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 bin_out=%0h at %0t",
                         bin_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bin_out", int'(bin_out), int'(e.bin));
                chk("overflow", int'(overflow), int'(e.ovf));
                chk("digit_err", int'(digit_err), int'(e.err));
            end
        end
        prev_done = done;
    end

    task automatic run(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic [7:0] eb, input logic eo, input logic ee,
                       input int exp_lat, input int inject);
        exp_t e;
        int   n;
        bit   got;
        @(negedge CLK);
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        e.bin = eb;
        e.ovf = eo;
        e.err = ee;
        q.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk("busy_rise", int'(busy), 1);
            end
            if (inject != 0 && n == inject) begin
                hundreds = 4'd0;
                tens     = 4'd0;
                ones     = 4'd7;
                start    = 1'b1;
            end
            if (inject != 0 && n == inject + 1) start = 1'b0;
            if (done) got = 1'b1;
        end
        chk("done_latency", n, exp_lat);
        @(negedge CLK);
        chk("busy_after_done", int'(busy), 0);
        chk("done_after_done", int'(done), 0);
    endtask

    initial begin
        int seen;
        checks    = 0;
        errors    = 0;
        prev_done = 1'b0;
        start     = 1'b0;
        hundreds  = 4'd0;
        tens      = 4'd0;
        ones      = 4'd0;
        RST_N     = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bin_out", int'(bin_out), 0);
        chk("reset_flags", int'({overflow, digit_err}), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        run(4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0, 11, 0);
        run(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0, 11, 0);
        run(4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0, 11, 0);
        run(4'd2, 4'd5, 4'd6, 8'hFF, 1'b1, 1'b0, 11, 0);
        run(4'd9, 4'd9, 4'd9, 8'hFF, 1'b1, 1'b0, 11, 0);
        run(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0, 11, 0);
        run(4'd1, 4'hA, 4'd3, 8'h00, 1'b0, 1'b1, 2, 0);
        run(4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1'b0, 11, 3);
        repeat (15) @(negedge CLK);

        // Abort a conversion of 200 after five iterations.
        hundreds = 4'd2;
        tens     = 4'd0;
        ones     = 4'd0;
        start    = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bin_out", int'(bin_out), 0);
        chk("abort_flags", int'({overflow, digit_err}), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        seen  = 0;
        repeat (25) begin
            @(negedge CLK);
            if (done) seen++;
        end
        chk("no_done_after_abort", seen, 0);

        run(4'd0, 4'd1, 4'd7, 8'h11, 1'b0, 1'b0, 11, 0);
        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
